// File: rtl/bnn_conv_pkg.sv
// bnn_conv_pkg: shared FSM encoding and constants for the binary conv engine
package bnn_conv_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, HDR, FILL, CONV, DONE} state_t;
  localparam int KSIZE = 3;
  localparam int DEFAULT_THRESH = 5;
  localparam logic [31:0] END_HDR = 32'hFFFF_FFFF;
endpackage

// File: rtl/bnn_pe.sv
// bnn_pe: XNOR-popcount-threshold on one 3x3 binary window
module bnn_pe (
  input  logic [8:0] kernel,
  input  logic [8:0] window,
  input  logic [3:0] thresh,
  output logic       hit
);
  logic [8:0] match;
  logic [3:0] cnt;
  always_comb begin
    match = ~(kernel ^ window);
    cnt = '0;
    for (int i = 0; i < 9; i++) cnt = cnt + 4'(match[i]);
    hit = cnt >= thresh;
  end
endmodule

// File: rtl/bnn_conv_engine.sv
// bnn_conv_engine: streams N x N binary matrices through a 3x3 XNOR conv into SRAM
// BNN_CONV_THRESH_EN: threshold loaded from wmem[1][3:0] instead of fixed majority
module bnn_conv_engine
  import bnn_conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_wmem_read_address,
  input  logic [DATA_W-1:0] wmem_dut_read_data
);
  localparam int NW = $clog2(DATA_W + 1);
  localparam int PW = DATA_W - 2;
  state_t state;
  logic ph;
  logic [8:0] kernel;
  logic [3:0] thresh;
  logic [DATA_W-1:0] r0, r1, r2;
  logic [NW-1:0] n, rows_rd;
  logic [ADDR_W-1:0] out_addr;
  logic [PW-1:0] hits, mask;
  logic end_hdr, unused_w;
  assign unused_w = ^wmem_dut_read_data;
  assign end_hdr = sram_dut_read_data < DATA_W'(KSIZE) || sram_dut_read_data > DATA_W'(DATA_W) ||
                   sram_dut_read_data == END_HDR[DATA_W-1:0];
`ifndef BNN_CONV_THRESH_EN
  assign thresh = 4'(DEFAULT_THRESH);
`endif
  // r0 is the oldest row; kernel bit 3*r+c pairs with row r, column j+c
  for (genvar j = 0; j < PW; j++) begin : g_pe
    bnn_pe u_pe (
      .kernel(kernel),
      .window({r2[j+2:j], r1[j+2:j], r0[j+2:j]}),
      .thresh(thresh),
      .hit(hits[j])
    );
    assign mask[j] = j < int'(n) - 2;
  end
  // every memory read spends ph=0 waiting on the SRAM and captures at ph=1
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state <= IDLE;
      ph <= 1'b0;
      kernel <= '0;
`ifdef BNN_CONV_THRESH_EN
      thresh <= '0;
`endif
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
      n <= '0;
      rows_rd <= '0;
      out_addr <= '0;
      dut_busy <= 1'b0;
      dut_sram_read_address <= '0;
      dut_sram_write_address <= '0;
      dut_sram_write_data <= '0;
      dut_sram_write_enable <= 1'b0;
      dut_wmem_read_address <= '0;
    end else begin
      dut_sram_write_enable <= 1'b0;
      case (state)
        IDLE: if (dut_run) begin
          state <= LOAD_W;
          dut_busy <= 1'b1;
          ph <= 1'b0;
          out_addr <= '0;
          dut_sram_read_address <= '0;
          dut_wmem_read_address <= '0;
        end
        LOAD_W: begin
          ph <= ~ph;
          if (ph) begin
`ifdef BNN_CONV_THRESH_EN
            if (dut_wmem_read_address == '0) begin
              kernel <= wmem_dut_read_data[8:0];
              dut_wmem_read_address <= ADDR_W'(1);
            end else begin
              thresh <= wmem_dut_read_data[3:0];
              state <= HDR;
            end
`else
            kernel <= wmem_dut_read_data[8:0];
            state <= HDR;
`endif
          end
        end
        HDR: begin
          ph <= ~ph;
          if (ph) begin
            if (end_hdr) state <= DONE;
            else begin
              n <= NW'(sram_dut_read_data);
              rows_rd <= '0;
              dut_sram_read_address <= dut_sram_read_address + ADDR_W'(1);
              state <= FILL;
            end
          end
        end
        FILL: begin
          ph <= ~ph;
          if (ph) begin
            r0 <= r1;
            r1 <= r2;
            r2 <= sram_dut_read_data;
            rows_rd <= rows_rd + NW'(1);
            dut_sram_read_address <= dut_sram_read_address + ADDR_W'(1);
            if (rows_rd >= NW'(2)) state <= CONV;
          end
        end
        CONV: begin
          dut_sram_write_enable <= 1'b1;
          dut_sram_write_address <= out_addr;
          dut_sram_write_data <= DATA_W'(hits & mask);
          out_addr <= out_addr + ADDR_W'(1);
          state <= rows_rd == n ? HDR : FILL;
        end
        DONE: begin
          state <= IDLE;
          dut_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_bnn_conv_engine.sv
// tb_bnn_conv_engine: randomized run-level checks against a matrix-level conv model
module tb_bnn_conv_engine;
  logic clk = 1'b0, reset_b = 1'b1, dut_run = 1'b0;
  logic dut_busy, dut_sram_write_enable;
  logic [11:0] dut_sram_read_address, dut_sram_write_address, dut_wmem_read_address;
  logic [15:0] sram_dut_read_data, dut_sram_write_data, wmem_dut_read_data;
  logic [15:0] isram [0:4095];
  logic [15:0] wmem [0:4095];
  int exp_addr [$];
  logic [15:0] exp_data [$];
  int checks = 0, failures = 0, nwrites = 0, busy_cyc = 0, wp = 0;

  bnn_conv_engine #(.DATA_W(16), .ADDR_W(12)) dut (
    .clk(clk), .reset_b(reset_b), .dut_run(dut_run), .dut_busy(dut_busy),
    .dut_sram_read_address(dut_sram_read_address), .sram_dut_read_data(sram_dut_read_data),
    .dut_sram_write_address(dut_sram_write_address), .dut_sram_write_data(dut_sram_write_data),
    .dut_sram_write_enable(dut_sram_write_enable), .dut_wmem_read_address(dut_wmem_read_address),
    .wmem_dut_read_data(wmem_dut_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    sram_dut_read_data <= isram[dut_sram_read_address];
    wmem_dut_read_data <= wmem[dut_wmem_read_address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (dut_busy) busy_cyc++;
    if (reset_b && dut_sram_write_enable) begin
      nwrites++;
      if (exp_addr.size() == 0) chk("unexpected_write", 32'(dut_sram_write_address), 32'hFFFF_FFFF);
      else begin
        chk("wr_addr", 32'(dut_sram_write_address), 32'(exp_addr.pop_front()));
        chk("wr_data", 32'(dut_sram_write_data), 32'(exp_data.pop_front()));
      end
    end
  end

  // model: walk headers from address 0 and convolve each matrix directly
  task automatic build_expect();
    int a, oa, n, t, cnt;
    logic [15:0] w;
    logic [8:0] k;
    exp_addr.delete();
    exp_data.delete();
    k = wmem[0][8:0];
`ifdef BNN_CONV_THRESH_EN
    t = int'(wmem[1][3:0]);
`else
    t = 5;
`endif
    a = 0;
    oa = 0;
    forever begin
      n = int'(isram[a]);
      if (n < 3 || n > 16) break;
      for (int r = 0; r <= n - 3; r++) begin
        w = '0;
        for (int j = 0; j <= n - 3; j++) begin
          cnt = 0;
          for (int rr = 0; rr < 3; rr++)
            for (int c = 0; c < 3; c++)
              if (k[3*rr+c] == isram[a+1+r+rr][j+c]) cnt++;
          w[j] = cnt >= t;
        end
        exp_addr.push_back(oa);
        exp_data.push_back(w);
        oa++;
      end
      a += n + 1;
    end
  endtask

  task automatic put(input logic [15:0] v);
    isram[wp] = v;
    wp++;
  endtask

  task automatic add_mat(input int n);
    put(16'(n));
    for (int i = 0; i < n; i++) put(16'($urandom));
  endtask

  task automatic wait_busy(input logic val, input string name);
    int i = 0;
    while (dut_busy !== val && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(dut_busy), 32'(val));
  endtask

  task automatic start();
    @(negedge clk);
    busy_cyc = 0;
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
    chk("busy_after_run", 32'(dut_busy), 32'd1);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
  endtask

  task automatic run(input string name);
    build_expect();
    start();
    wait_busy(1'b0, {name, "_busy_fall"});
    repeat (4) @(negedge clk);
    chk({name, "_pending"}, 32'(exp_addr.size()), 32'd0);
    chk({name, "_stays_idle"}, 32'(dut_busy), 32'd0);
  endtask

  initial begin
    int base;
    logic [15:0] ends [6];
    ends = '{16'd0, 16'd1, 16'd2, 16'd17, 16'hFFFF, 16'h8000};
    for (int i = 0; i < 4096; i++) begin
      isram[i] = '0;
      wmem[i] = '0;
    end
    wmem[1] = 16'd5;
    #2 reset_b = 1'b0;
    #1;
    chk("rst_busy", 32'(dut_busy), 32'd0);
    chk("rst_we", 32'(dut_sram_write_enable), 32'd0);
    chk("rst_waddr", 32'(dut_sram_write_address), 32'd0);
    chk("rst_wdata", 32'(dut_sram_write_data), 32'd0);
    chk("rst_raddr", 32'(dut_sram_read_address), 32'd0);
    chk("rst_wmaddr", 32'(dut_wmem_read_address), 32'd0);
    repeat (2) @(negedge clk);
    reset_b = 1'b1;

    wmem[0] = 16'h01FF;
    wp = 0;
    put(16'd3);
    repeat (3) put(16'h0007);
    put(16'hFFFF);
    build_expect();
    chk("model_n3_count", 32'(exp_data.size()), 32'd1);
    chk("model_n3_word", 32'(exp_data[0]), 32'h0001);
    run("n3_ones");

    wmem[0] = 16'h0000;
    wp = 0;
    put(16'd16);
    repeat (16) put(16'h0000);
    put(16'hFFFF);
    build_expect();
    chk("model_n16_count", 32'(exp_data.size()), 32'd14);
    chk("model_n16_word", 32'(exp_data[13]), 32'h3FFF);
    run("n16_zero");

    wmem[0] = 16'($urandom);
    wp = 0;
    add_mat(4);
    add_mat(10);
    put(16'd0);
    build_expect();
    chk("model_4_10_count", 32'(exp_data.size()), 32'd10);
    chk("model_4_10_upper", 32'(exp_data[1] & 16'hFFFC), 32'd0);
    run("n4_n10");

    for (int t = 0; t < 6; t++) begin
      wmem[0] = 16'($urandom);
`ifdef BNN_CONV_THRESH_EN
      wmem[1] = 16'($urandom_range(0, 15));
`endif
      wp = 0;
      for (int m = 0; m < int'($urandom_range(1, 3)); m++) add_mat(int'($urandom_range(3, 16)));
      put(ends[$urandom_range(0, 5)]);
      run("random");
    end
    wmem[1] = 16'd5;

    wmem[0] = 16'($urandom);
    wp = 0;
    add_mat(16);
    add_mat(7);
    put(16'hFFFF);
    build_expect();
    start();
    base = nwrites;
    for (int i = 0; i < 2000 && nwrites < base + 3; i++) @(negedge clk);
    chk("pre_reset_writes", 32'(nwrites - base >= 3), 32'd1);
    #2 reset_b = 1'b0;
    #1;
    exp_addr.delete();
    exp_data.delete();
    chk("mid_rst_busy", 32'(dut_busy), 32'd0);
    chk("mid_rst_we", 32'(dut_sram_write_enable), 32'd0);
    chk("mid_rst_waddr", 32'(dut_sram_write_address), 32'd0);
    chk("mid_rst_wdata", 32'(dut_sram_write_data), 32'd0);
    chk("mid_rst_raddr", 32'(dut_sram_read_address), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("in_rst_we", 32'(dut_sram_write_enable), 32'd0);
    end
    reset_b = 1'b1;
    base = nwrites;
    repeat (6) @(negedge clk);
    chk("post_rst_quiet", 32'(nwrites - base), 32'd0);
    chk("post_rst_busy", 32'(dut_busy), 32'd0);
    run("rerun");

    wp = 0;
    put(16'd2);
    add_mat(5);
    put(16'hFFFF);
    base = nwrites;
    run("n2_first");
    chk("n2_no_writes", 32'(nwrites - base), 32'd0);
    chk("n2_busy_short", 32'(busy_cyc > 0 && busy_cyc <= 8), 32'd1);

`ifdef BNN_CONV_THRESH_EN
    wmem[0] = 16'($urandom);
    wmem[1] = 16'd9;
    wp = 0;
    put(16'd3);
    put({13'd0, wmem[0][2:0]});
    put({13'd0, wmem[0][5:3] ^ 3'b010});
    put({13'd0, wmem[0][8:6]});
    put(16'hFFFF);
    build_expect();
    chk("model_t9_word", 32'(exp_data[0]), 32'd0);
    run("t9_mismatch");
    wmem[1] = 16'd0;
    wp = 0;
    add_mat(8);
    put(16'hFFFF);
    build_expect();
    chk("model_t0_word", 32'(exp_data[5]), 32'h003F);
    run("t0_all_ones");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bnn_conv_engine.md
BNN_CONV_ENGINE -- requirements
Module: bnn_conv_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16: SRAM word width and maximum matrix dimension, legal range 8..32.
REQ-002 SHALL have parameter ADDR_W, default 12: SRAM address width for both memories.
REQ-003 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-004 SHALL have port reset_b, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port dut_run, input, 1 bit: start request, sampled in IDLE only.
REQ-006 SHALL have port dut_busy, output, 1 bit: run in progress.
REQ-007 SHALL have port dut_sram_read_address, output, ADDR_W bits: input SRAM read address.
REQ-008 SHALL have port sram_dut_read_data, input, DATA_W bits: input SRAM data, 1-cycle read latency.
REQ-009 SHALL have port dut_sram_write_address, output, ADDR_W bits: output SRAM write address.
REQ-010 SHALL have port dut_sram_write_data, output, DATA_W bits: output SRAM write data.
REQ-011 SHALL have port dut_sram_write_enable, output, 1 bit: write strobe, one word per asserted cycle.
REQ-012 SHALL have port dut_wmem_read_address, output, ADDR_W bits: weight SRAM read address.
REQ-013 SHALL have port wmem_dut_read_data, input, DATA_W bits: weight SRAM data, 1-cycle read latency.

Function
REQ-014 SHALL use a state machine with states IDLE, LOAD_W, HDR, FILL, CONV, DONE; IDLE->LOAD_W on dut_run; LOAD_W->HDR after kernel (and threshold) captured; HDR->FILL on a legal header; HDR->DONE on end header; FILL->CONV after 3 rows buffered; CONV->FILL on next row; CONV->HDR after last row of matrix; DONE->IDLE after one cycle.
REQ-015 SHALL read weight word at wmem address 0 in LOAD_W; kernel bit 3*r+c applies to row r (0 = oldest) and column c (0 = LSB) of the window.
REQ-016 SHALL read the input stream from address 0: header word N, then N row words, next header at the following address, repeated.
REQ-017 SHALL treat a header with N < 3, N > DATA_W, or all-ones as end of run, with no write for that header.
REQ-018 SHALL compute output bit j of output row r as 1 when popcount(XNOR(kernel, window rows r..r+2, columns j..j+2)) >= T, for j in 0..N-3.
REQ-019 SHALL emit N-2 output words per matrix, each holding N-2 result bits LSB-aligned with upper bits zero.
REQ-020 SHALL write output words to consecutive addresses starting at 0, contiguous across matrices within a run.
REQ-021 SHALL register dut_sram_write_address, dut_sram_write_data and dut_sram_write_enable, all valid in the same cycle.
REQ-022 SHALL issue at most one input read per cycle; each matrix after the first SHALL start without returning to IDLE.
REQ-023 SHALL assert dut_busy the cycle after dut_run is accepted and deassert it the cycle after the last write (DONE).
REQ-024 SHALL ignore dut_run while dut_busy is high.

Reset
REQ-025 SHALL drive all outputs to 0, the state to IDLE and all counters and row buffers to 0 while reset_b is low, with no clock required.
REQ-026 SHALL abandon any in-progress run on reset with no further writes; the next dut_run restarts at input and output address 0.

Configuration
REQ-027 SHALL support macro BNN_CONV_THRESH_EN.
- Defined: LOAD_W also reads wmem address 1, and T = bits [3:0] of that word; T = 0 makes every output bit 1; T > 9 makes every output bit 0.
- Undefined: T is fixed at 5 (majority) and only wmem address 0 is read.

Structure
REQ-028 SHALL place the state encoding, KSIZE = 3, DEFAULT_THRESH = 5 and the end-header constant in shared package bnn_conv_pkg.
REQ-029 SHALL implement one XNOR-popcount-compare per output column in sub-module bnn_pe (inputs: 9-bit kernel, 9-bit window, 4-bit T; output: 1 bit), instantiated DATA_W-2 times.

Verification
REQ-030 SHALL pass: kernel 9'h1FF, N=3 with rows 3'b111, then end header -> one write, addr 0, data 16'h0001; dut_busy falls after it.
REQ-031 SHALL pass: kernel 0, N=16 with all-zero rows -> 14 writes, addr 0..13, data 16'h3FFF each.
REQ-032 SHALL pass: N=4 matrix then N=10 matrix back-to-back -> writes at addr 0..1 (upper 14 bits 0), then addr 2..9 (upper 8 bits 0).
REQ-033 SHALL pass, with BNN_CONV_THRESH_EN: T=9 with one mismatched window bit -> that output bit 0; T=0 -> all N-2 bits 1.
REQ-034 SHALL pass: reset_b pulsed low mid-CONV -> outputs 0 immediately, no writes; a new dut_run rewrites from addr 0 with correct data.
REQ-035 SHALL pass: first header N=2 -> no writes; dut_busy high for the LOAD_W/HDR/DONE cycles only.
